// File: rtl/vec_pkg.sv
// Shared encodings for the vector datapath controller: op codes, register
// indices, register-file write sources and the sequencer state type.
package vec_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_SUM   = 2'b10;
  localparam logic [1:0] OP_PROD  = 2'b11;

  localparam logic [1:0] REG_A1 = 2'b00;
  localparam logic [1:0] REG_A2 = 2'b01;
  localparam logic [1:0] REG_A3 = 2'b10;
  localparam logic [1:0] REG_A4 = 2'b11;

  localparam logic [1:0] SRC_MEM    = 2'b00;
  localparam logic [1:0] SRC_ALU_LO = 2'b01;
  localparam logic [1:0] SRC_ALU_HI = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR, S_ALU_GO, S_ALU_WAIT, S_WB_LO, S_WB_HI, S_DONE
  } state_e;

endpackage

// File: rtl/vec_op_timeout.sv
// Wait-cycle counter shared by the memory-read and ALU wait states.
module vec_op_timeout #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;

  // Flags the waiting cycle in which the count reaches TIMEOUT, so the
  // caller can still let a same-cycle strobe win over the abort.
  assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (clr_i)              cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + TO_W'(1);
  end

endmodule

// File: rtl/vec_op_controller.sv
// Command sequencer for the 512-bit vector datapath: turns Load/Store/Sum/
// Product commands into memory, register-file and ALU control strobes.
module vec_op_controller
  import vec_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_reg,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  output logic              rf_we,
  output logic [1:0]        rf_wsel,
  output logic [1:0]        rf_rsel,
  output logic [1:0]        rf_src,
  output logic              alu_start,
  output logic              alu_op,
  input  logic              alu_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        reg_q;
  logic              err_q;
  logic              to_clr, to_en, to_expired;

  assign to_clr = (state_q == S_RD_REQ) || (state_q == S_ALU_GO);
  assign to_en  = (state_q == S_RD_WAIT) || (state_q == S_ALU_WAIT);

  vec_op_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      reg_q   <= REG_A1;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          addr_q <= cmd_addr;
          reg_q  <= cmd_reg;
          err_q  <= 1'b0;
          case (cmd_op)
            OP_LOAD:  state_q <= S_RD_REQ;
            OP_STORE: state_q <= S_WR;
            default:  state_q <= S_ALU_GO;
          endcase
        end
        S_RD_REQ:  state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (mem_rvalid) state_q <= S_DONE;
          else if (to_expired) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WR:       state_q <= S_DONE;
        S_ALU_GO:   state_q <= S_ALU_WAIT;
        S_ALU_WAIT: begin
          if (alu_done) state_q <= S_WB_LO;
          else if (to_expired) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WB_LO: state_q <= S_WB_HI;
        S_WB_HI: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset
  // drops them at once; only the load capture follows mem_rvalid live.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    rf_we     = 1'b0;
    rf_wsel   = REG_A1;
    rf_rsel   = REG_A1;
    rf_src    = SRC_MEM;
    alu_start = 1'b0;
    alu_op    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_RD_REQ:  mem_en = 1'b1;
      S_RD_WAIT: if (mem_rvalid) begin
        rf_we   = 1'b1;
        rf_wsel = reg_q;
        rf_src  = SRC_MEM;
      end
      S_WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        rf_rsel = reg_q;
      end
      S_ALU_GO: begin
        alu_start = 1'b1;
        alu_op    = (op_q == OP_PROD);
      end
      S_ALU_WAIT: alu_op = (op_q == OP_PROD);
      S_WB_LO: begin
        rf_we   = 1'b1;
        rf_wsel = REG_A3;
        rf_src  = SRC_ALU_LO;
        alu_op  = (op_q == OP_PROD);
      end
      S_WB_HI: begin
        rf_we   = 1'b1;
        rf_wsel = REG_A4;
        rf_src  = SRC_ALU_HI;
        alu_op  = (op_q == OP_PROD);
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_op_controller.sv
// Directed bench for vec_op_controller: cycle-by-cycle control-strobe tables.
module tb_vec_op_controller;
  import vec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [8:0] cmd_addr = '0;
  logic [1:0] cmd_reg = 2'b00;
  logic       mem_rvalid = 1'b0;
  logic       alu_done = 1'b0;
  logic       cmd_ready, mem_en, mem_we, rf_we, alu_start, alu_op, busy, done, err;
  logic [8:0] mem_addr;
  logic [1:0] rf_wsel, rf_rsel, rf_src;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_op_controller #(.ADDR_W(9), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_reg(cmd_reg),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_rsel(rf_rsel), .rf_src(rf_src),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .busy(busy), .done(done), .err(err)
  );

  // {ready,busy,mem_en,mem_we,rf_we,wsel,src,rsel,alu_start,alu_op,done,err}
  function automatic logic [14:0] obs();
    return {cmd_ready, busy, mem_en, mem_we, rf_we, rf_wsel, rf_src, rf_rsel,
            alu_start, alu_op, done, err};
  endfunction

  function automatic logic [14:0] mk(input logic rdy, bsy, en, we, rfwe,
                                     input logic [1:0] wsel, src, rsel,
                                     input logic st, aop, dn, er);
    return {rdy, bsy, en, we, rfwe, wsel, src, rsel, st, aop, dn, er};
  endfunction

  localparam logic [14:0] IDLE_V  = 15'b1_0_0_0_0_00_00_00_0_0_0_0;
  localparam logic [14:0] BUSY_V  = 15'b0_1_0_0_0_00_00_00_0_0_0_0;
  localparam logic [14:0] RDREQ_V = 15'b0_1_1_0_0_00_00_00_0_0_0_0;
  localparam logic [14:0] DONE_OK = 15'b0_1_0_0_0_00_00_00_0_0_1_0;
  localparam logic [14:0] DONE_ER = 15'b0_1_0_0_0_00_00_00_0_0_1_1;

  task automatic step(input logic rv, input logic ad);
    @(posedge clk); #1;
    cmd_valid = 1'b0; mem_rvalid = rv; alu_done = ad;
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [8:0] a, input logic [1:0] r);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_reg = r;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd_op = OP_STORE; cmd_addr = 9'h0AA; cmd_reg = REG_A3;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== IDLE_V || mem_addr !== 9'h000) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b addr=%h exp=%b addr=000", c, obs(), mem_addr, IDLE_V);
      end
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (obs() !== IDLE_V) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs(), IDLE_V);
    end
  endtask

  task automatic test_load();
    logic [14:0] ev[$];
    ev = '{RDREQ_V, BUSY_V, mk(0,1,0,0,1,REG_A2,SRC_MEM,2'b00,0,0,0,0), DONE_OK, IDLE_V};
    issue(OP_LOAD, 9'h1FF, REG_A2);
    for (int c = 1; c <= ev.size(); c++) begin
      step(c == 3, 1'b0);
      checks++;
      if (obs() !== ev[c-1]) begin
        failures++;
        $display("FAIL load cyc=%0d got=%b exp=%b", c, obs(), ev[c-1]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 9'h1FF) begin
          failures++;
          $display("FAIL load_addr got=%h exp=1ff", mem_addr);
        end
      end
    end
  endtask

  task automatic test_store(input logic [8:0] a, input logic [1:0] r);
    logic [14:0] ev[$];
    ev = '{mk(0,1,1,1,0,2'b00,2'b00,r,0,0,0,0), DONE_OK, IDLE_V};
    issue(OP_STORE, a, r);
    for (int c = 1; c <= ev.size(); c++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs() !== ev[c-1]) begin
        failures++;
        $display("FAIL store cyc=%0d got=%b exp=%b", c, obs(), ev[c-1]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== a) begin
          failures++;
          $display("FAIL store_addr got=%h exp=%h", mem_addr, a);
        end
      end
    end
  endtask

  // ad_cyc: cycle after accept in which alu_done is driven (>= 2)
  task automatic test_alu(input logic [1:0] op, input int ad_cyc);
    logic [14:0] ev[$];
    logic aop;
    aop = (op == OP_PROD);
    ev.push_back(mk(0,1,0,0,0,2'b00,2'b00,2'b00,1,aop,0,0));
    for (int c = 2; c <= ad_cyc; c++) ev.push_back(mk(0,1,0,0,0,2'b00,2'b00,2'b00,0,aop,0,0));
    ev.push_back(mk(0,1,0,0,1,REG_A3,SRC_ALU_LO,2'b00,0,aop,0,0));
    ev.push_back(mk(0,1,0,0,1,REG_A4,SRC_ALU_HI,2'b00,0,aop,0,0));
    ev.push_back(DONE_OK);
    ev.push_back(IDLE_V);
    issue(op, 9'h010, REG_A1);
    for (int c = 1; c <= ev.size(); c++) begin
      step(1'b0, c == ad_cyc);
      checks++;
      if (obs() !== ev[c-1]) begin
        failures++;
        $display("FAIL alu op=%0d cyc=%0d got=%b exp=%b", op, c, obs(), ev[c-1]);
      end
    end
  endtask

  // late=1: mem_rvalid lands on the 16th wait cycle and must still win
  task automatic test_timeout(input logic late);
    logic [14:0] ev[$];
    ev.push_back(RDREQ_V);
    for (int c = 2; c <= 16; c++) ev.push_back(BUSY_V);
    ev.push_back(late ? mk(0,1,0,0,1,REG_A4,SRC_MEM,2'b00,0,0,0,0) : BUSY_V);
    ev.push_back(late ? DONE_OK : DONE_ER);
    ev.push_back(IDLE_V);
    issue(OP_LOAD, 9'h003, REG_A4);
    for (int c = 1; c <= ev.size(); c++) begin
      step(late && (c == 17), 1'b0);
      checks++;
      if (obs() !== ev[c-1]) begin
        failures++;
        $display("FAIL timeout late=%0d cyc=%0d got=%b exp=%b", late, c, obs(), ev[c-1]);
      end
    end
  endtask

  task automatic test_reset_midop();
    issue(OP_PROD, 9'h020, REG_A1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (obs() !== mk(0,1,0,0,0,2'b00,2'b00,2'b00,0,1,0,0)) begin
      failures++;
      $display("FAIL midop_wait got=%b", obs());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== IDLE_V) begin
      failures++;
      $display("FAIL midop_async got=%b exp=%b", obs(), IDLE_V);
    end
    step(1'b0, 1'b1);
    checks++;
    if (obs() !== IDLE_V) begin
      failures++;
      $display("FAIL midop_held got=%b exp=%b", obs(), IDLE_V);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, c == 0);
      checks++;
      if (obs() !== IDLE_V) begin
        failures++;
        $display("FAIL stray_alu_done cyc=%0d got=%b exp=%b", c, obs(), IDLE_V);
      end
    end
    test_store(9'h055, REG_A4);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store(9'h1FF, REG_A2);
    test_alu(OP_PROD, 4);
    test_alu(OP_SUM, 4);
    test_alu(OP_SUM, 2);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
